stimulus_conditioner: RTL and testbench

- Sits directly upstream of the stopwatch control FSM and produces its 4-bit stimulus bundle.
- Takes the four raw board pushbuttons (start/pause, lap, reset, clear) and synchronises each to the clock domain.
- Debounces each button independently.
- Emits exactly one single-cycle pulse per debounced press, with bit order {start_pause, lap, reset, clear} = stimulus[3:0].

---
 rtl/stimulus_conditioner.sv | 140 ++++++++++++++
 tb/tb_stimulus_conditioner.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/stimulus_conditioner.sv
// Synchronises, debounces and edge-detects four board pushbuttons into one-cycle stimulus pulses.
// Optional macro STIM_ONEHOT_EN restricts stimulus to one-hot (priority reset > clear > start_pause > lap).
module stimulus_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 19,
   parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [3:0] key_raw,
   output logic [3:0] stimulus,
   output logic [3:0] key_held
);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } btn_state_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]       RELEASED = {4{KEY_ACTIVE_LOW}};

   logic [3:0] sync1;
   logic [3:0] sync2;
   logic [3:0] pressed;
   logic [3:0] pulse_next;
   logic [3:0] held_next;
   logic [3:0] stim_next;

   // NOTE: synchroniser flops reset to the released key level so a reset never looks like a press.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= RELEASED;
         sync2 <= RELEASED;
      end else begin
         // NOTE: non-blocking assignments keep the two flops a true two-stage shift.
         sync1 <= key_raw;
         sync2 <= sync1;
      end
   end

   assign pressed = sync2 ^ RELEASED;

   for (genvar g = 0; g < 4; g++) begin : g_btn
      btn_state_e       state;
      btn_state_e       state_next;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_next;
      logic [CNT_W-1:0] cnt_inc;
      logic             pulse;

      assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            state <= state_next;
            cnt   <= cnt_next;
         end
      end

      // NOTE: every output of this block is defaulted first so no path can infer a latch.
      always_comb begin
         state_next = state;
         cnt_next   = cnt;
         pulse      = 1'b0;
         case (state)
            IDLE: begin
               if (pressed[g]) begin
                  state_next = PRESS_WAIT;
                  cnt_next   = '0;
               end
            end
            PRESS_WAIT: begin
               if (!pressed[g]) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_next = HELD;
                  cnt_next   = '0;
                  pulse      = 1'b1;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
            HELD: begin
               if (!pressed[g]) begin
                  state_next = RELEASE_WAIT;
                  cnt_next   = '0;
               end
            end
            RELEASE_WAIT: begin
               if (pressed[g]) begin
                  state_next = HELD;
                  cnt_next   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         endcase
      end

      assign pulse_next[g] = pulse;
      assign held_next[g]  = (state_next == HELD) || (state_next == RELEASE_WAIT);
   end

   always_comb begin
      stim_next = pulse_next;
`ifdef STIM_ONEHOT_EN
      // Bit map {start_pause, lap, reset, clear}; suppressed pulses are simply dropped.
      if (pulse_next[1])      stim_next = 4'b0010;
      else if (pulse_next[0]) stim_next = 4'b0001;
      else if (pulse_next[3]) stim_next = 4'b1000;
      else if (pulse_next[2]) stim_next = 4'b0100;
      else                    stim_next = 4'b0000;
`endif
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stimulus <= '0;
         key_held <= '0;
      end else begin
         stimulus <= stim_next;
         key_held <= held_next;
      end
   end

endmodule

// File: tb/tb_stimulus_conditioner.sv
// Self-checking bench for stimulus_conditioner: directed scenarios plus random key activity,
// compared every cycle against a run-length debounce model.
module tb_stimulus_conditioner;

   localparam int         D        = 8;
   localparam int         CW       = 4;
   localparam logic [3:0] RELEASED = 4'hF;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [3:0] key_raw;
   logic [3:0] stimulus;
   logic [3:0] key_held;

   always #5 clock = ~clock;

   stimulus_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W(CW),
      .KEY_ACTIVE_LOW(1'b1)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .key_raw(key_raw),
      .stimulus(stimulus),
      .key_held(key_held)
   );

   int tests = 0;
   int fails = 0;

   // Reference model state: raw samples delayed two edges, accepted level, run of differing samples.
   logic [3:0] h1, h2, acc, exp_stim;
   int         run [4];
   int         cyc;

   // Observation bookkeeping for the directed scenarios.
   int         pulse_cnt  [4];
   int         last_pulse [4];
   logic [3:0] held_seen;
   logic [3:0] first_stim;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [3:0] arbitrate(input logic [3:0] p);
`ifdef STIM_ONEHOT_EN
      if (p[1]) return 4'b0010;
      if (p[0]) return 4'b0001;
      if (p[3]) return 4'b1000;
      if (p[2]) return 4'b0100;
      return 4'b0000;
`else
      return p;
`endif
   endfunction

   // A button's accepted level flips once D+1 consecutive synchronised samples disagree with it.
   task automatic model_edge();
      logic [3:0] p;
      logic [3:0] pulse;
      pulse = '0;
      if (!reset_n) begin
         h1  = RELEASED;
         h2  = RELEASED;
         acc = '0;
         for (int i = 0; i < 4; i++) run[i] = 0;
      end else begin
         p  = h2 ^ RELEASED;
         h2 = h1;
         h1 = key_raw;
         for (int i = 0; i < 4; i++) begin
            if (p[i] != acc[i]) begin
               run[i]++;
               if (run[i] == D + 1) begin
                  acc[i]   = p[i];
                  run[i]   = 0;
                  pulse[i] = p[i];
               end
            end else begin
               run[i] = 0;
            end
         end
      end
      exp_stim = arbitrate(pulse);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         cyc++;
         model_edge();
         @(negedge clock);
         check("stimulus", 32'(stimulus), 32'(exp_stim));
         check("key_held", 32'(key_held), 32'(acc));
         for (int i = 0; i < 4; i++) begin
            if (stimulus[i] === 1'b1) begin
               pulse_cnt[i]++;
               last_pulse[i] = cyc;
            end
         end
         held_seen |= key_held;
         if (first_stim == 4'b0000 && stimulus !== 4'b0000) first_stim = stimulus;
      end
   endtask

   task automatic clear_stats();
      for (int i = 0; i < 4; i++) begin
         pulse_cnt[i]  = 0;
         last_pulse[i] = -1;
      end
      held_seen  = '0;
      first_stim = '0;
   endtask

   initial begin
      int t0;
      int lat;
      logic [3:0] simul_exp;

      reset_n = 1'b0;
      key_raw = RELEASED;
      h1 = RELEASED; h2 = RELEASED; acc = '0; exp_stim = '0; cyc = 0;
      for (int i = 0; i < 4; i++) run[i] = 0;
      clear_stats();

      // Reset state
      step(3);
      check("reset_stimulus", 32'(stimulus), 32'h0);
      check("reset_key_held", 32'(key_held), 32'h0);
      reset_n = 1'b1;
      step(4);

      // Clean press on start_pause
      clear_stats();
      key_raw[3] = 1'b0;
      t0 = cyc + 1;
      step(20);
      check("clean_held_during_press", 32'(key_held[3]), 32'h1);
      key_raw[3] = 1'b1;
      step(15);
      lat = last_pulse[3] - t0;
      check("clean_pulse_count", 32'(pulse_cnt[3]), 32'd1);
      check("clean_latency_in_window", 32'((lat >= D + 1) && (lat <= D + 3)), 32'd1);
      check("clean_held_released", 32'(key_held[3]), 32'h0);

      // Bounce on lap: toggles every 3 cycles, never accepted
      clear_stats();
      for (int k = 0; k < 10; k++) begin
         key_raw[2] = ~key_raw[2];
         step(3);
      end
      key_raw[2] = 1'b1;
      step(15);
      check("bounce_pulse_count", 32'(pulse_cnt[2]), 32'd0);
      check("bounce_held_never", 32'(held_seen[2]), 32'd0);

      // Release bounce on clear
      clear_stats();
      key_raw[0] = 1'b0;
      step(20);
      for (int k = 0; k < 6; k++) begin
         key_raw[0] = ~key_raw[0];
         step(2);
      end
      key_raw[0] = 1'b1;
      step(20);
      check("release_bounce_pulse_count", 32'(pulse_cnt[0]), 32'd1);

      // Long hold on reset button
      clear_stats();
      key_raw[1] = 1'b0;
      step(200);
      check("long_hold_held", 32'(key_held[1]), 32'h1);
      key_raw[1] = 1'b1;
      step(15);
      check("long_hold_pulse_count", 32'(pulse_cnt[1]), 32'd1);

      // Reset mid-press on start_pause
      clear_stats();
      key_raw[3] = 1'b0;
      step(5);
      reset_n = 1'b0;
      step(2);
      check("midreset_no_pulse", 32'(pulse_cnt[3]), 32'd0);
      reset_n = 1'b1;
      t0 = cyc + 1;
      step(20);
      lat = last_pulse[3] - t0;
      check("midreset_pulse_count", 32'(pulse_cnt[3]), 32'd1);
      check("midreset_latency_in_window", 32'((lat >= D + 1) && (lat <= D + 3)), 32'd1);
      key_raw[3] = 1'b1;
      step(15);

      // Simultaneous start_pause and reset
      clear_stats();
      key_raw = 4'b0101;
      step(14);
`ifdef STIM_ONEHOT_EN
      simul_exp = 4'b0010;
`else
      simul_exp = 4'b1010;
`endif
      check("simultaneous_stimulus", 32'(first_stim), 32'(simul_exp));
      check("simultaneous_held", 32'(key_held), 32'(4'b1010));
      key_raw = RELEASED;
      step(15);

      // Random key activity with one reset pulse part-way
      for (int s = 0; s < 60; s++) begin
         key_raw = 4'($urandom);
         if (s == 30) begin
            reset_n = 1'b0;
            step(2);
            reset_n = 1'b1;
         end
         step($urandom_range(1, 14));
      end
      key_raw = RELEASED;
      step(15);
      check("final_idle_held", 32'(key_held), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
